// File: rtl/psum_out_fifo_pkg.sv
// Shared constants and helpers for the partial-sum output staging FIFO.
// Optional error reporting is enabled with the PSUM_OFIFO_ERR_EN macro.
package psum_out_fifo_pkg;

   localparam int PSUM_OFIFO_COL   = 8;
   localparam int PSUM_OFIFO_BW    = 16;
   localparam int PSUM_OFIFO_DEPTH = 64;

   // Bit positions inside the err vector.
   localparam int ERR_OVF = 1;
   localparam int ERR_UDF = 0;

   // Pointer width: one extra MSB beyond the address bits separates full from empty.
   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/psum_out_fifo_if.sv
// Handshake bundle between the PE-array columns and the SFU-side consumer.
// The err vector exists only when PSUM_OFIFO_ERR_EN is defined.
interface psum_out_fifo_if #(
   parameter int col     = 8,
   parameter int psum_bw = 16
);
   logic [col-1:0]         wr;
   logic [col*psum_bw-1:0] in;
   logic                   rd;
   logic                   o_valid;
   logic                   o_full;
   logic                   o_ready;
   logic [col*psum_bw-1:0] out;
   logic                   out_valid;
`ifdef PSUM_OFIFO_ERR_EN
   logic [1:0]             err;

   modport master (output wr, in, rd,
                   input  o_valid, o_full, o_ready, out, out_valid, err);
   modport slave  (input  wr, in, rd,
                   output o_valid, o_full, o_ready, out, out_valid, err);
`else
   modport master (output wr, in, rd,
                   input  o_valid, o_full, o_ready, out, out_valid);
   modport slave  (input  wr, in, rd,
                   output o_valid, o_full, o_ready, out, out_valid);
`endif
endinterface

// File: rtl/psum_out_fifo_lane.sv
// Single-lane FIFO: flop storage, synchronous write, combinational head read.
// A push to a full lane is taken only when a pop frees the slot in the same cycle.
module psum_lane_fifo
   import psum_out_fifo_pkg::*;
#(
   parameter int psum_bw = PSUM_OFIFO_BW,
   parameter int depth   = PSUM_OFIFO_DEPTH
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               push,
   input  logic [psum_bw-1:0] push_data,
   input  logic               pop,
   output logic [psum_bw-1:0] head,
   output logic               empty,
   output logic               full
);

   localparam int PW = ptr_width(depth);
   localparam int AW = PW - 1;

   logic [PW-1:0]      wr_ptr;
   logic [PW-1:0]      rd_ptr;
   logic [psum_bw-1:0] mem [depth];
   logic               push_ok;
   logic               pop_ok;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign push_ok = push && (!full || pop);
   assign pop_ok  = pop && !empty;
   assign head    = mem[rd_ptr[AW-1:0]];

   // Pointer update; reset empties the lane without touching storage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      end
   end

   // Storage write; contents after reset are don't-care so no reset here.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/psum_out_fifo.sv
// Output staging buffer: aligns skewed per-column partial-sum streams into
// row-wide words for the SFU, with a registered one-cycle pop latency.
// Define PSUM_OFIFO_ERR_EN to add sticky overflow/underflow flags on err.
module psum_out_fifo
   import psum_out_fifo_pkg::*;
#(
   parameter int col     = PSUM_OFIFO_COL,
   parameter int psum_bw = PSUM_OFIFO_BW,
   parameter int depth   = PSUM_OFIFO_DEPTH
) (
   input logic             clk,
   input logic             reset,
   psum_out_fifo_if.slave  bus
);

   logic [col-1:0]         lane_empty;
   logic [col-1:0]         lane_full;
   logic [col*psum_bw-1:0] heads;
   logic                   o_valid;
   logic                   o_full;
   logic                   pop_ok;
   logic [col*psum_bw-1:0] out_q;
   logic                   out_valid_q;

   for (genvar g = 0; g < col; g++) begin : g_lane
      psum_lane_fifo #(
         .psum_bw (psum_bw),
         .depth   (depth)
      ) u_lane (
         .clk       (clk),
         .reset     (reset),
         .push      (bus.wr[g]),
         .push_data (bus.in[g*psum_bw +: psum_bw]),
         .pop       (pop_ok),
         .head      (heads[g*psum_bw +: psum_bw]),
         .empty     (lane_empty[g]),
         .full      (lane_full[g])
      );
   end

   // Status comes from lane pointers only, so it never depends on wr/rd.
   assign o_valid = &(~lane_empty);
   assign o_full  = |lane_full;
   assign pop_ok  = bus.rd && o_valid;

   assign bus.o_valid   = o_valid;
   assign bus.o_full    = o_full;
   assign bus.o_ready   = ~o_full;
   assign bus.out       = out_q;
   assign bus.out_valid = out_valid_q;

   // Output row register: captures all lane heads on an accepted pop and holds otherwise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= pop_ok;
         if (pop_ok) out_q <= heads;
      end
   end

`ifdef PSUM_OFIFO_ERR_EN
   logic [1:0]     err_q;
   logic [col-1:0] dropped;

   assign dropped = bus.wr & lane_full & {col{~pop_ok}};
   assign bus.err = err_q;

   // Sticky error flags: dropped pushes and pops requested while a lane is empty.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_q <= '0;
      end else begin
         if (|dropped)            err_q[ERR_OVF] <= 1'b1;
         if (bus.rd && !o_valid)  err_q[ERR_UDF] <= 1'b1;
      end
   end
`endif

endmodule

// File: doc/psum_out_fifo.md
# psum_out_fifo

Output-staging buffer between the PE array columns and the SFU. Each of `col` array columns pushes 16-bit partial sums independently as they drain. The block aligns these skewed per-column streams into one row-wide word. It presents that word to the SFU's `psum_in` with a registered one-cycle pop latency.

## Interface
- `col`, 8, number of array columns / FIFO lanes
- `psum_bw`, 16, partial-sum width per lane
- `depth`, 64, entries per lane; power of two, ≥ 2
- `clk`  in  1  clock
- `reset`  in  1  async, active-high
- `wr`  in  col  per-lane push strobe
- `in`  in  col*psum_bw  per-lane push data; lane k at bits [(k+1)*psum_bw-1 : k*psum_bw]
- `rd`  in  1  row pop request
- `o_valid`  out  1  every lane non-empty
- `o_full`  out  1  any lane full
- `o_ready`  out  1  ~o_full
- `out`  out  col*psum_bw  popped row, registered
- `out_valid`  out  1  one-cycle pulse: `out` holds a newly popped row
- `err`  out  2  {overflow, underflow}; present only with `PSUM_OFIFO_ERR_EN`

Interface rule (already decided): reset `reset`, asynchronous, active-high; clock `clk`.

## Operation
- Each lane has its own read pointer, write pointer and storage.
  - Pointers are log2(depth)+1 bits and wrap naturally.
  - Lane empty: pointers equal.
  - Lane full: MSBs differ and the low bits are equal.
- Pop is accepted in a cycle when `rd && o_valid`. `o_valid` is evaluated from the pre-edge state.
  - On an accepted pop, every lane's head word is loaded into `out`, `out_valid` asserts next cycle, and every read pointer advances by one.
  - `rd` while `!o_valid` is ignored: no pointer moves, `out` holds, `out_valid` = 0.
- Push to lane k happens when `wr[k]`. It is accepted if lane k is not full, or if a pop is accepted in the same cycle.
  - A push to a full lane with no pop is dropped and the lane state is unchanged.
- Simultaneous push and pop on a lane leaves its occupancy unchanged.
- Push to an empty lane with `rd` in the same cycle: the push is accepted, the pop is not accepted, and the data is visible for pop one cycle later.
- Lanes are fully independent for pushes. The `wr` bits may be any pattern.
- Reset mid-operation: all pointers go to 0 and all lanes become empty. In-flight data is discarded and storage contents are don't-care.

## Timing
- Reset values: `o_valid`=0, `o_full`=0, `o_ready`=1, `out`=0, `out_valid`=0, `err`=0.
- `o_valid`, `o_full` and `o_ready` are combinational from pointers only, never from `wr`/`rd`.
- Push-to-`o_valid` latency: if the last empty lane is pushed at edge N, `o_valid`=1 after edge N.
- Pop latency: pop accepted at edge N gives `out`/`out_valid` after edge N. `out` holds until the next accepted pop.
- Back-to-back pops are allowed every cycle while `o_valid` holds. Maximum throughput is one row per cycle.
- Storage is a flop array with a synchronous write and a combinational head read.

## Configuration
- `PSUM_OFIFO_ERR_EN` defined:
  - `err[1]` (overflow) is set sticky when any `wr[k]` is dropped because lane k is full.
  - `err[0]` (underflow) is set sticky when `rd` is seen while `!o_valid`.
  - Both flags clear only on `reset`.
- Not defined: the `err` port and its logic are absent, and drops and ignored pops are silent.

## Structure
- A shared package holds:
  - default parameter constants (`PSUM_OFIFO_DEPTH`=64);
  - a function for pointer width (clog2(depth)+1);
  - the `err` bit-index constants (`ERR_OVF`=1, `ERR_UDF`=0).
- One sub-module, `psum_lane_fifo`: a single-lane FIFO of width `psum_bw` and depth `depth`.
  - Ports: push, push data, pop, head data, empty, full.
  - The top instantiates it `col` times via generate and does the AND-reduce (`o_valid`), OR-reduce (`o_full`), output register and error logic.

## Test plan
- Aligned fill/drain: `col`=8; push `wr`=8'hFF with lane k = 16'h0100+k for 3 cycles, then `rd` for 3 cycles.
  - Expect `out_valid` on 3 consecutive cycles, each row lane k = 0x0100+k in order, then `o_valid`=0.
- Skew: push lane k at cycle k only (diagonal, one word each).
  - Expect `o_valid` to rise exactly one cycle after the lane-7 push, then a single pop returns all 8 words.
- Full boundary: push lane 0 `depth`=64 times.
  - Expect `o_full`=1 and `o_ready`=0.
  - A 65th push is dropped; with `PSUM_OFIFO_ERR_EN`, `err[1]`=1.
  - After filling the other lanes and doing 64 pops, the lane-0 data is 0..63 with no 64th value.
- Full with simultaneous push+pop: with all lanes full, assert `rd` and `wr`=8'hFF with value 16'hBEEF in the same cycle.
  - Expect `o_full` to stay 1 and no drop; after 64 pops the last row is 0xBEEF in all lanes.
- Empty read: `rd`=1 from reset with no pushes.
  - Expect `out_valid`=0, `out`=0, pointers unchanged; with `PSUM_OFIFO_ERR_EN`, `err[0]`=1.
- Mid-operation reset: push 5 rows, pop 2, assert `reset` for 1 cycle.
  - Expect `o_valid`=0, `out`=0, `err`=0 immediately.
  - A subsequent single-row push/pop returns only the new data.
